// File: rtl/register_write_arbiter.sv
// register_write_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback stage and one long-latency unit. Pipeline writebacks win the port
// and are never buffered; long-latency results wait in a small FIFO and drain
// whenever the port is free. A starvation guard raises stallRequest once the
// FIFO head has waited STARVE_LIMIT edges, forcing the head out. pendingMask
// exposes the destination registers still sitting in the FIFO for hazard
// detection.
//
// Optional feature: define REGISTER_WRITE_ARBITER_BYPASS_EN to let an accepted
// long-latency result skip the FIFO (latency 1) when the FIFO is empty and no
// pipeline writeback is present. Without it every accepted result is queued.
module register_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        wbValid,
    input  logic [4:0]  wbIndex,
    input  logic [31:0] wbData,
    input  logic        extValid,
    output logic        extReady,
    input  logic [4:0]  extIndex,
    input  logic [31:0] extData,
    output logic [4:0]  writeRegisterIndex,
    output logic [31:0] writeRegisterData,
    output logic        shouldWrite,
    output logic        stallRequest,
    output logic [31:0] pendingMask,
    output logic        protocolError
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [4:0]        idx_mem_q  [FIFO_DEPTH];
    logic [31:0]       data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_count_q, wait_count_d;

    // Registered write port
    logic [4:0]        wr_index_q, wr_index_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              proto_err_q, proto_err_d;

    logic              fifo_empty;
    logic              ext_accept;
    logic              wb_grant;
    logic              pop;
    logic              push;
    logic              bypass;
    logic [4:0]        head_index;
    logic [31:0]       head_data;
    logic [FIFO_DEPTH-1:0] slot_valid;

    assign fifo_empty   = (count_q == '0);
    assign extReady     = (count_q < DEPTH_C);
    assign stallRequest = (wait_count_q >= LIMIT_C);
    assign ext_accept   = extValid && extReady;
    assign wb_grant     = wbValid && !stallRequest;
    // A stalled (illegal) writeback is dropped, so the head still drains.
    assign pop          = !wb_grant && !fifo_empty;

`ifdef REGISTER_WRITE_ARBITER_BYPASS_EN
    assign bypass = ext_accept && fifo_empty && !wbValid;
`else
    assign bypass = 1'b0;
`endif

    assign push       = ext_accept && !bypass;
    assign head_index = idx_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];

    // Slot gi is live when its distance from the read pointer is below the count;
    // pointer arithmetic wraps naturally because the depth is a power of two.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_valid
            logic [PTR_W-1:0] slot_off;
            assign slot_off       = PTR_W'(gi) - rd_ptr_q;
            assign slot_valid[gi] = ({1'b0, slot_off} < count_q);
        end
    endgenerate

    // Hazard mask: OR of one-hot decodes of every live FIFO entry, r0 excluded
    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i]) begin
                pendingMask[idx_mem_q[i]] = 1'b1;
            end
        end
        pendingMask[0] = 1'b0;
    end

    // Port grant: pipeline first, then FIFO head, then bypassed ext; r0 never writes
    always_comb begin
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        if (wb_grant) begin
            wr_index_d = wbIndex;
            wr_data_d  = wbData;
            wr_en_d    = (wbIndex != 5'd0);
        end else if (pop) begin
            wr_index_d = head_index;
            wr_data_d  = head_data;
            wr_en_d    = (head_index != 5'd0);
        end else if (bypass) begin
            wr_index_d = extIndex;
            wr_data_d  = extData;
            wr_en_d    = (extIndex != 5'd0);
        end
    end

    // FIFO pointers, occupancy, head wait counter and sticky protocol error
    always_comb begin
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        proto_err_d = proto_err_q || (wbValid && stallRequest);
        if (fifo_empty || pop) begin
            wait_count_d = '0;
        end else if (wait_count_q < LIMIT_C) begin
            wait_count_d = wait_count_q + WAIT_W'(1);
        end else begin
            wait_count_d = wait_count_q;
        end
    end

    // FIFO payload storage; contents beyond the count are never observed
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem_q[wr_ptr_q]  <= extIndex;
            data_mem_q[wr_ptr_q] <= extData;
        end
    end

    // Control state and registered write port, cleared asynchronously
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wait_count_q <= '0;
            wr_index_q   <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wait_count_q <= wait_count_d;
            wr_index_q   <= wr_index_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign writeRegisterIndex = wr_index_q;
    assign writeRegisterData  = wr_data_q;
    assign shouldWrite        = wr_en_q;
    assign protocolError      = proto_err_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized and directed bench for register_write_arbiter, compared every
// cycle against a queue-based model of the arbitration rules.
module tb_register_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetN;
    logic        wbValid;
    logic [4:0]  wbIndex;
    logic [31:0] wbData;
    logic        extValid;
    logic        extReady;
    logic [4:0]  extIndex;
    logic [31:0] extData;
    logic [4:0]  writeRegisterIndex;
    logic [31:0] writeRegisterData;
    logic        shouldWrite;
    logic        stallRequest;
    logic [31:0] pendingMask;
    logic        protocolError;

    register_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .resetN(resetN),
        .wbValid(wbValid),
        .wbIndex(wbIndex),
        .wbData(wbData),
        .extValid(extValid),
        .extReady(extReady),
        .extIndex(extIndex),
        .extData(extData),
        .writeRegisterIndex(writeRegisterIndex),
        .writeRegisterData(writeRegisterData),
        .shouldWrite(shouldWrite),
        .stallRequest(stallRequest),
        .pendingMask(pendingMask),
        .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    int          m_wait;
    bit          m_perr;
    logic        m_sw;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].idx] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_wait = 0;
        m_perr = 1'b0;
        m_sw   = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present at the edge
    task automatic model_step();
        bit   stall  = (m_wait >= LIMIT);
        int   sz     = q.size();
        bit   acc    = extValid && (sz < DEPTH);
        bit   popped = 1'b0;
        bit   byp    = 1'b0;
        ent_t e;
`ifdef REGISTER_WRITE_ARBITER_BYPASS_EN
        byp = acc && (sz == 0) && !wbValid;
`endif
        m_sw = 1'b0;
        if (wbValid && !stall) begin
            m_sw = (wbIndex != 0);
            m_idx = wbIndex;
            m_data = wbData;
        end else if (sz > 0) begin
            e = q.pop_front();
            popped = 1'b1;
            m_sw = (e.idx != 0);
            m_idx = e.idx;
            m_data = e.data;
        end else if (byp) begin
            m_sw = (extIndex != 0);
            m_idx = extIndex;
            m_data = extData;
        end
        if (acc && !byp) begin
            e.idx = extIndex;
            e.data = extData;
            q.push_back(e);
        end
        if (sz == 0 || popped) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
        if (wbValid && stall) m_perr = 1'b1;
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("shouldWrite", {31'd0, shouldWrite}, {31'd0, m_sw});
            if (m_sw) begin
                chk("writeIndex", {27'd0, writeRegisterIndex}, {27'd0, m_idx});
                chk("writeData", writeRegisterData, m_data);
            end
            chk("extReady", {31'd0, extReady}, {31'd0, (q.size() < DEPTH)});
            chk("stallRequest", {31'd0, stallRequest}, {31'd0, (m_wait >= LIMIT)});
            chk("pendingMask", pendingMask, model_mask());
            chk("protocolError", {31'd0, protocolError}, {31'd0, m_perr});
        end
    end

    // Present inputs, take one edge, advance the model, return 1 time unit later
    task automatic cycle(input logic wv, input logic [4:0] wi, input logic [31:0] wd,
                         input logic ev, input logic [4:0] ei, input logic [31:0] ed);
        wbValid = wv; wbIndex = wi; wbData = wd;
        extValid = ev; extIndex = ei; extData = ed;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        wbValid = 0; wbIndex = 0; wbData = 0;
        extValid = 0; extIndex = 0; extData = 0;
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sw"}, {31'd0, shouldWrite}, 32'd0);
        chk({tag, "_idx"}, {27'd0, writeRegisterIndex}, 32'd0);
        chk({tag, "_data"}, writeRegisterData, 32'd0);
        chk({tag, "_ready"}, {31'd0, extReady}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stallRequest}, 32'd0);
        chk({tag, "_mask"}, pendingMask, 32'd0);
        chk({tag, "_perr"}, {31'd0, protocolError}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        wbValid = 0; wbIndex = 0; wbData = 0;
        extValid = 0; extIndex = 0; extData = 0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        do_reset();

        // wb only
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("wb_sw", {31'd0, shouldWrite}, 32'd1);
        chk("wb_idx", {27'd0, writeRegisterIndex}, 32'd5);
        chk("wb_data", writeRegisterData, 32'hDEADBEEF);
        chk("wb_mask", pendingMask, 32'd0);

        // contention: wb wins, ext follows one cycle later
        cycle(1, 5'd3, 32'h33, 1, 5'd7, 32'h11);
        chk("cont1_idx", {27'd0, writeRegisterIndex}, 32'd3);
        chk("cont1_mask", pendingMask, 32'h80);
        cycle(0, 0, 0, 0, 0, 0);
        chk("cont2_sw", {31'd0, shouldWrite}, 32'd1);
        chk("cont2_idx", {27'd0, writeRegisterIndex}, 32'd7);
        chk("cont2_data", writeRegisterData, 32'h11);
        chk("cont2_mask", pendingMask, 32'd0);

        // index 0 is consumed but never written
        cycle(0, 0, 0, 1, 5'd0, 32'h1234);
        chk("idx0_sw1", {31'd0, shouldWrite}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("idx0_sw2", {31'd0, shouldWrite}, 32'd0);
        chk("idx0_ready", {31'd0, extReady}, 32'd1);
        chk("idx0_mask", pendingMask, 32'd0);

        // starvation, back-pressure and protocol error
        do_reset();
        cycle(1, 5'd1, 32'h1, 1, 5'd10, 32'hA0);
        cycle(1, 5'd2, 32'h2, 1, 5'd11, 32'hB0);
        chk("full_ready", {31'd0, extReady}, 32'd0);
        chk("full_mask", pendingMask, 32'h0000_0C00);
        cycle(1, 5'd3, 32'h3, 1, 5'd12, 32'hC0);
        cycle(1, 5'd4, 32'h4, 1, 5'd12, 32'hC0);
        chk("starve_e3", {31'd0, stallRequest}, 32'd0);
        cycle(1, 5'd5, 32'h5, 1, 5'd12, 32'hC0);
        chk("starve_e4", {31'd0, stallRequest}, 32'd1);
        chk("starve_ready", {31'd0, extReady}, 32'd0);
        cycle(1, 5'd9, 32'h99, 0, 0, 0);
        chk("starve_pop_idx", {27'd0, writeRegisterIndex}, 32'd10);
        chk("starve_pop_data", writeRegisterData, 32'hA0);
        chk("perr_set", {31'd0, protocolError}, 32'd1);
        chk("starve_fall", {31'd0, stallRequest}, 32'd0);
        chk("starve_mask", pendingMask, 32'h0000_0800);
        cycle(0, 0, 0, 0, 0, 0);
        chk("drain_idx", {27'd0, writeRegisterIndex}, 32'd11);
        chk("drain_data", writeRegisterData, 32'hB0);
        chk("perr_sticky", {31'd0, protocolError}, 32'd1);

        // reset mid-drain
        do_reset();
        chk("perr_cleared", {31'd0, protocolError}, 32'd0);
        cycle(1, 5'd4, 32'h4, 1, 5'd20, 32'hC0);
        cycle(1, 5'd5, 32'h5, 1, 5'd21, 32'hC1);
        chk("pre_reset_mask", pendingMask, 32'h0030_0000);
        #2;
        chk_en = 1'b0;
        resetN = 1'b0;
        wbValid = 0; extValid = 0;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        chk_en = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        chk("no_stale_sw", {31'd0, shouldWrite}, 32'd0);
        chk("no_stale_mask", pendingMask, 32'd0);
        cycle(0, 0, 0, 1, 5'd12, 32'hC12);
`ifdef REGISTER_WRITE_ARBITER_BYPASS_EN
        chk("bypass_sw", {31'd0, shouldWrite}, 32'd1);
        chk("bypass_idx", {27'd0, writeRegisterIndex}, 32'd12);
        chk("bypass_mask", pendingMask, 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
`else
        chk("lone_ext_sw1", {31'd0, shouldWrite}, 32'd0);
        chk("lone_ext_mask", pendingMask, 32'h0000_1000);
        cycle(0, 0, 0, 0, 0, 0);
        chk("lone_ext_sw2", {31'd0, shouldWrite}, 32'd1);
        chk("lone_ext_idx", {27'd0, writeRegisterIndex}, 32'd12);
        chk("lone_ext_data", writeRegisterData, 32'hC12);
`endif

        // randomized traffic, mostly protocol-respecting
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic wv;
            wv = ($urandom_range(0, 99) < 60);
            if ((m_wait >= LIMIT) && ($urandom_range(0, 99) >= 3)) wv = 1'b0;
            cycle(wv, 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
            if (n == 1000) do_reset();
        end
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
